// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants and the fetch-control state encoding.
// Decode and the sign extender reuse the opcode constants.
package legv8_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_INC    = 4;

  localparam logic [5:0] OP_B   = 6'b000101;
  localparam logic [7:0] OP_CBZ = 8'b10110100;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_REDIR = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_register.sv
// Program counter flop: reset, hold, load of a redirect target, or increment by PC_INC.
// The increment wraps modulo 2^PC_W.
module pc_register
  import legv8_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            load,
  input  logic [PC_W-1:0] load_value,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  // A load beats a hold so a taken branch redirects even while stalled.
  always_comb begin
    pc_d = pc_q + PC_W'(PC_INC);
    if (load) begin
      pc_d = load_value;
    end else if (hold) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// LEGv8 fetch stage with the IF/ID pipeline register, redirect/flush/stall handling
// and a saturating counter of bubble cycles seen by decode.
module if_id_fetch_stage
  import legv8_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               pc_src,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic [CNT_W-1:0]   bubble_count
);

  fetch_state_e fsm_d, fsm_q;

  logic [PC_W-1:0]    pc;
  logic               pc_hold;
  logic               pc_load;

  logic [PC_W-1:0]    if_id_pc_d, if_id_pc_q;
  logic [INSTR_W-1:0] if_id_instr_d, if_id_instr_q;
  logic               if_id_valid_d, if_id_valid_q;
  logic [CNT_W-1:0]   bubble_count_d, bubble_count_q;
  logic               redir_pending;

  pc_register #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk        (clk),
    .reset      (reset),
    .hold       (pc_hold),
    .load       (pc_load),
    .load_value (branch_target),
    .pc         (pc)
  );

  assign redir_pending = (fsm_q == FETCH_REDIR);

  // Priority: redirect > flush > stall > normal fetch.
  always_comb begin
    fsm_d         = FETCH_RUN;
    pc_hold       = 1'b0;
    pc_load       = 1'b0;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;

    if (pc_src) begin
      fsm_d         = FETCH_REDIR;
      pc_load       = 1'b1;
      if_id_pc_d    = '0;
      if_id_instr_d = INSTR_W'(NOP_INSTR);
      if_id_valid_d = 1'b0;
    end else if (flush) begin
      pc_hold       = stall;
      if_id_pc_d    = '0;
      if_id_instr_d = INSTR_W'(NOP_INSTR);
      if_id_valid_d = 1'b0;
    end else if (stall) begin
      // While the redirect target is still being fetched the latch keeps its bubble.
      pc_hold       = 1'b1;
      if_id_valid_d = if_id_valid_q & ~redir_pending;
    end else begin
      if_id_pc_d    = pc;
      if_id_instr_d = imem_data;
      if_id_valid_d = 1'b1;
    end
  end

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (!if_id_valid_q && (bubble_count_q != '1)) begin
      bubble_count_d = bubble_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q          <= FETCH_RUN;
      if_id_pc_q     <= '0;
      if_id_instr_q  <= INSTR_W'(NOP_INSTR);
      if_id_valid_q  <= 1'b0;
      bubble_count_q <= '0;
    end else begin
      fsm_q          <= fsm_d;
      if_id_pc_q     <= if_id_pc_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_valid_q  <= if_id_valid_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign imem_addr    = pc;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_valid  = if_id_valid_q;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: a hand-computed vector table, a counter
// saturation sequence, then random control traffic against a rule-level reference model.
module tb_if_id_fetch_stage;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int NVEC    = 23;

  logic               clk = 1'b0;
  logic               reset;
  logic               stall;
  logic               pc_src;
  logic               flush;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [PC_W-1:0]    if_id_pc;
  logic [INSTR_W-1:0] if_id_instr;
  logic               if_id_valid;
  logic [CNT_W-1:0]   bubble_count;

  always #5 clk = ~clk;

  if_id_fetch_stage #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (64'h0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_src        (pc_src),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .bubble_count  (bubble_count)
  );

  // Instruction memory contents: two fixed words, everything else derived from the address.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    if (a == 64'h0) return 32'hF840_0000;
    if (a == 64'h4) return 32'h1400_0003;
    return 32'h8B00_0000 | {8'h00, a[23:0]};
  endfunction

  always_comb imem_data = memWord(imem_addr);

  typedef struct {
    logic        rst, stl, src, fls;
    logic [63:0] tgt;
    logic [63:0] eAddr, ePc;
    logic [31:0] eInstr;
    logic        eValid;
    int          eCnt;
  } vec_t;

  vec_t vecs[NVEC];

  int total = 0;
  int bad   = 0;

  logic [63:0] mPc, mIpc;
  logic [31:0] mInstr;
  logic        mValid;
  int          mCnt;

  function automatic vec_t mk(input logic r, input logic s, input logic p, input logic f,
                              input logic [63:0] t, input logic [63:0] a, input logic [63:0] ip,
                              input logic [31:0] ins, input logic v, input int c);
    vec_t x;
    x.rst = r; x.stl = s; x.src = p; x.fls = f; x.tgt = t;
    x.eAddr = a; x.ePc = ip; x.eInstr = ins; x.eValid = v; x.eCnt = c;
    return x;
  endfunction

  // Reference model: one clock of the fetch rules, in plain arithmetic.
  task automatic modelStep();
    if (reset) begin
      mPc = 64'h0; mIpc = 64'h0; mInstr = 32'h0; mValid = 1'b0; mCnt = 0;
    end else begin
      if (!mValid && mCnt < CNT_MAX) mCnt = mCnt + 1;
      if (pc_src) begin
        mPc = branch_target; mIpc = 64'h0; mInstr = 32'h0; mValid = 1'b0;
      end else if (flush) begin
        mIpc = 64'h0; mInstr = 32'h0; mValid = 1'b0;
        if (!stall) mPc = mPc + 64'd4;
      end else if (!stall) begin
        mIpc = mPc; mInstr = memWord(mPc); mValid = 1'b1;
        mPc = mPc + 64'd4;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic p, input logic f,
                               input logic [63:0] t);
    reset = r; stall = s; pc_src = p; flush = f; branch_target = t;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string name, input int idx, input logic [63:0] got,
                          input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s step=%0d got=%h want=%h", name, idx, got, want);
    end
  endtask

  task automatic checkOutput(input int idx, input logic [63:0] a, input logic [63:0] ip,
                             input logic [31:0] ins, input logic v, input int c);
    checkOne("imem_addr", idx, imem_addr, a);
    checkOne("if_id_pc", idx, if_id_pc, ip);
    checkOne("if_id_instr", idx, {32'h0, if_id_instr}, {32'h0, ins});
    checkOne("if_id_valid", idx, {63'h0, if_id_valid}, {63'h0, v});
    checkOne("bubble_count", idx, {60'h0, bubble_count}, 64'(c));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_src = 1'b0; flush = 1'b0; branch_target = 64'h0;
    mPc = 64'h0; mIpc = 64'h0; mInstr = 32'h0; mValid = 1'b0; mCnt = 0;

    //               rst stl src fls target                  addr                    if_id_pc                instr          v  cnt
    vecs[0]  = mk(1, 0, 0, 0, 64'h0,                 64'h0,                 64'h0,                 32'h0,         0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 64'h0,                 64'h0,                 64'h0,                 32'h0,         0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 64'h0,                 64'h4,                 64'h0,                 32'hF840_0000, 1, 1);
    vecs[3]  = mk(0, 0, 0, 0, 64'h0,                 64'h8,                 64'h4,                 32'h1400_0003, 1, 1);
    vecs[4]  = mk(0, 1, 0, 0, 64'h0,                 64'h8,                 64'h4,                 32'h1400_0003, 1, 1);
    vecs[5]  = mk(0, 1, 0, 0, 64'h0,                 64'h8,                 64'h4,                 32'h1400_0003, 1, 1);
    vecs[6]  = mk(0, 0, 0, 0, 64'h0,                 64'hC,                 64'h8,                 32'h8B00_0008, 1, 1);
    vecs[7]  = mk(0, 0, 0, 0, 64'h0,                 64'h10,                64'hC,                 32'h8B00_000C, 1, 1);
    vecs[8]  = mk(0, 0, 1, 0, 64'h40,                64'h40,                64'h0,                 32'h0,         0, 1);
    vecs[9]  = mk(0, 0, 0, 0, 64'h0,                 64'h44,                64'h40,                32'h8B00_0040, 1, 2);
    vecs[10] = mk(0, 1, 1, 1, 64'h80,                64'h80,                64'h0,                 32'h0,         0, 2);
    vecs[11] = mk(0, 0, 0, 0, 64'h0,                 64'h84,                64'h80,                32'h8B00_0080, 1, 3);
    vecs[12] = mk(0, 0, 1, 0, 64'h20,                64'h20,                64'h0,                 32'h0,         0, 3);
    vecs[13] = mk(0, 0, 0, 1, 64'h0,                 64'h24,                64'h0,                 32'h0,         0, 4);
    vecs[14] = mk(0, 0, 0, 0, 64'h0,                 64'h28,                64'h24,                32'h8B00_0024, 1, 5);
    vecs[15] = mk(0, 1, 0, 1, 64'h0,                 64'h28,                64'h0,                 32'h0,         0, 5);
    vecs[16] = mk(0, 0, 0, 0, 64'h0,                 64'h2C,                64'h28,                32'h8B00_0028, 1, 6);
    vecs[17] = mk(0, 0, 1, 0, 64'h100,               64'h100,               64'h0,                 32'h0,         0, 6);
    vecs[18] = mk(0, 0, 0, 0, 64'h0,                 64'h104,               64'h100,               32'h8B00_0100, 1, 7);
    vecs[19] = mk(1, 0, 0, 0, 64'h0,                 64'h0,                 64'h0,                 32'h0,         0, 0);
    vecs[20] = mk(0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,             32'h0,         0, 1);
    vecs[21] = mk(0, 0, 0, 0, 64'h0,                 64'h0,                 64'hFFFF_FFFF_FFFF_FFFC, 32'h8BFF_FFFC, 1, 2);
    vecs[22] = mk(0, 0, 0, 0, 64'h0,                 64'h4,                 64'h0,                 32'hF840_0000, 1, 2);

    #2;
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stl, vecs[i].src, vecs[i].fls, vecs[i].tgt);
      checkOutput(i, vecs[i].eAddr, vecs[i].ePc, vecs[i].eInstr, vecs[i].eValid, vecs[i].eCnt);
    end

    // Back-to-back redirects keep inserting bubbles until the counter pins at all-ones.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 64'h200 + 64'(i * 8));
      checkOutput(100 + i, mPc, mIpc, mInstr, mValid, mCnt);
    end
    checkOne("bubble_saturated", 199, {60'h0, bubble_count}, 64'(CNT_MAX));

    for (int i = 0; i < 400; i++) begin
      logic [63:0] t;
      t = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), t);
      checkOutput(200 + i, mPc, mIpc, mInstr, mValid, mCnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
